// File: rtl/robo_pkg.sv
// Shared definitions for the robo_seguidor wall-following controller:
// the state encodings, the state width and the sensor-vector bit positions.
package robo_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_PROCURANDO   = 3'd0,
    ST_ROTACIONANDO = 3'd1,
    ST_ACOMPANHANDO = 3'd2,
    ST_STANDBY      = 3'd3,
    ST_REMOVENDO    = 3'd4
  } state_t;

  localparam int SENS_W       = 4;
  localparam int SENS_HEAD    = 3;
  localparam int SENS_LEFT    = 2;
  localparam int SENS_UNDER   = 1;
  localparam int SENS_BARRIER = 0;

endpackage

// File: rtl/contador_sat.sv
// Up-counter that holds at its maximum value instead of wrapping.
// A synchronous clear takes priority over the enable.
module contador_sat #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/robo_seguidor.sv
// Wall-following robot controller: Moore FSM with debris removal, a rotation
// watchdog that parks the robot in STANDBY, and saturating activity counters.
module robo_seguidor
  import robo_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int ROT_LIMIT     = 8,
  parameter int REMOVE_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               head,
  input  logic               left,
  input  logic               under,
  input  logic               barrier,
  input  logic               retomar,
  output logic               avancar,
  output logic               girar,
  output logic               remover,
  output logic               travado,
  output logic [STATE_W-1:0] estado,
  output logic [CNT_W-1:0]   passos,
  output logic [CNT_W-1:0]   removidos
);

  localparam int ROT_W = $clog2(ROT_LIMIT + 1);
  localparam int REM_W = $clog2(REMOVE_CYCLES + 1);

  logic [SENS_W-1:0] sens;
  logic [1:0]        head_left;

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  logic [ROT_W-1:0]  rot_cnt_q, rot_cnt_d;
  logic [REM_W-1:0]  rem_cnt_q, rem_cnt_d;
  logic              travado_q, travado_d;
  logic              rem_entry;

  assign sens      = {head, left, under, barrier};
  assign head_left = {sens[SENS_HEAD], sens[SENS_LEFT]};

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    rot_cnt_d = rot_cnt_q;
    rem_cnt_d = rem_cnt_q;
    travado_d = travado_q;

    case (state_q)
      ST_STANDBY: begin
        if (retomar && !sens[SENS_UNDER]) begin
          state_d   = ST_PROCURANDO;
          travado_d = 1'b0;
        end
      end

      ST_REMOVENDO: begin
        if (sens[SENS_UNDER]) begin
          state_d = ST_STANDBY;
        end else if (rem_cnt_q == REM_W'(REMOVE_CYCLES - 1)) begin
          state_d = ret_q;
        end else begin
          rem_cnt_d = rem_cnt_q + 1'b1;
        end
      end

      ST_PROCURANDO, ST_ROTACIONANDO, ST_ACOMPANHANDO: begin
        if (sens[SENS_UNDER]) begin
          state_d = ST_STANDBY;
        end else if (sens[SENS_BARRIER]) begin
          state_d   = ST_REMOVENDO;
          ret_d     = state_q;
          rem_cnt_d = '0;
        end else begin
          case (state_q)
            ST_PROCURANDO: begin
              if (head_left == 2'b01) state_d = ST_ACOMPANHANDO;
              else if (head_left[1])  state_d = ST_ROTACIONANDO;
            end
            ST_ROTACIONANDO: begin
              if (head_left == 2'b01) begin
                state_d = ST_ACOMPANHANDO;
              end else if (rot_cnt_q == ROT_W'(ROT_LIMIT - 1)) begin
                state_d   = ST_STANDBY;
                travado_d = 1'b1;
              end else begin
                rot_cnt_d = rot_cnt_q + 1'b1;
              end
            end
            default: begin
              if (head_left == 2'b11)  state_d = ST_ROTACIONANDO;
              else if (!head_left[0])  state_d = ST_PROCURANDO;
            end
          endcase
        end
      end

      default: state_d = ST_PROCURANDO;
    endcase

    // Rotation budget survives only a detour through REMOVENDO.
    if ((state_d != ST_ROTACIONANDO) && (state_d != ST_REMOVENDO)) begin
      rot_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_PROCURANDO;
      ret_q     <= ST_PROCURANDO;
      rot_cnt_q <= '0;
      rem_cnt_q <= '0;
      travado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      rot_cnt_q <= rot_cnt_d;
      rem_cnt_q <= rem_cnt_d;
      travado_q <= travado_d;
    end
  end

  always_comb begin
    avancar = (state_q == ST_PROCURANDO) || (state_q == ST_ACOMPANHANDO);
    girar   = (state_q == ST_ROTACIONANDO);
    remover = (state_q == ST_REMOVENDO);
    travado = travado_q;
    estado  = state_q;
  end

  assign rem_entry = (state_q != ST_REMOVENDO) && (state_d == ST_REMOVENDO);

  contador_sat #(.W(CNT_W)) u_passos (
    .clock  (clock),
    .clear  (reset),
    .enable (avancar),
    .count  (passos)
  );

  contador_sat #(.W(CNT_W)) u_removidos (
    .clock  (clock),
    .clear  (reset),
    .enable (rem_entry),
    .count  (removidos)
  );

endmodule

// File: tb/tb_robo_seguidor.sv
// Scoreboard bench for robo_seguidor: directed steps queue expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_robo_seguidor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       head = 1'b0, left = 1'b0, under = 1'b0, barrier = 1'b0, retomar = 1'b0;
  logic       avancar, girar, remover, travado;
  logic [2:0] estado;
  logic [2:0] passos, removidos;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit started  = 1'b0;

  typedef struct {
    int         cyc;
    string      name;
    logic [6:0] outs;
    int         passos;
    int         removidos;
  } exp_t;

  exp_t sb[$];

  robo_seguidor #(.CNT_W(3), .ROT_LIMIT(8), .REMOVE_CYCLES(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .head      (head),
    .left      (left),
    .under     (under),
    .barrier   (barrier),
    .retomar   (retomar),
    .avancar   (avancar),
    .girar     (girar),
    .remover   (remover),
    .travado   (travado),
    .estado    (estado),
    .passos    (passos),
    .removidos (removidos)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: one-hot output check plus scoreboard pops due this cycle.
  always @(negedge clock) begin
    exp_t e;
    logic [6:0] act;
    if (started) begin
      n_assert++;
      if ($countones({avancar, girar, remover}) > 1) begin
        n_fail++;
        $display("FAIL onehot cyc=%0d got av/gi/re=%b%b%b required at most one high",
                 cyc, avancar, girar, remover);
      end
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = {estado, avancar, girar, remover, travado};
      n_assert++;
      if (act !== e.outs || int'(passos) != e.passos || int'(removidos) != e.removidos) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got est/av/gi/re/tr=%b passos=%0d removidos=%0d required %b passos=%0d removidos=%0d",
                 e.name, cyc, act, passos, removidos, e.outs, e.passos, e.removidos);
      end
    end
  end

  // in = {head,left,under,barrier,retomar}; flags = {av,gi,re,tr}
  task automatic step(input bit rst, input logic [4:0] in, input logic [2:0] st,
                      input logic [3:0] flags, input int p, input int r, input string nm);
    exp_t e;
    reset   = rst;
    head    = in[4];
    left    = in[3];
    under   = in[2];
    barrier = in[1];
    retomar = in[0];
    e.cyc       = cyc + 1;
    e.name      = nm;
    e.outs      = {st, flags};
    e.passos    = p;
    e.removidos = r;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1;
    step(1'b1, 5'b00000, 3'd0, 4'b1000, 0, 0, "reset");
    started = 1'b1;
    for (int k = 1; k <= 5; k++) step(1'b0, 5'b00000, 3'd0, 4'b1000, k, 0, "idle");
    step(1'b0, 5'b01000, 3'd2, 4'b1000, 6, 0, "to_acomp");
    step(1'b0, 5'b01010, 3'd4, 4'b0010, 7, 1, "barrier_in");
    for (int k = 0; k < 3; k++) step(1'b0, 5'b01000, 3'd4, 4'b0010, 7, 1, "removing");
    step(1'b0, 5'b01000, 3'd2, 4'b1000, 7, 1, "rem_return");
    step(1'b0, 5'b11000, 3'd1, 4'b0100, 7, 1, "to_rot");
    for (int k = 0; k < 7; k++) step(1'b0, 5'b11000, 3'd1, 4'b0100, 7, 1, "rotating");
    step(1'b0, 5'b11000, 3'd3, 4'b0001, 7, 1, "rot_limit");
    step(1'b0, 5'b00101, 3'd3, 4'b0001, 7, 1, "resume_blocked");
    step(1'b0, 5'b00001, 3'd0, 4'b1000, 7, 1, "resume");
    step(1'b0, 5'b00010, 3'd4, 4'b0010, 7, 2, "barrier_proc");
    step(1'b0, 5'b00000, 3'd4, 4'b0010, 7, 2, "rem_2nd");
    step(1'b0, 5'b00100, 3'd3, 4'b0000, 7, 2, "rem_abort");
    step(1'b0, 5'b00001, 3'd0, 4'b1000, 7, 2, "resume2");
    step(1'b0, 5'b10000, 3'd1, 4'b0100, 7, 2, "head_rot");
    step(1'b0, 5'b10000, 3'd1, 4'b0100, 7, 2, "rot_mid");
    step(1'b1, 5'b10000, 3'd0, 4'b1000, 0, 0, "reset_mid_rot");
    step(1'b0, 5'b00000, 3'd0, 4'b1000, 1, 0, "post_reset");
    step(1'b0, 5'b00110, 3'd3, 4'b0000, 2, 0, "under_prio");
    step(1'b0, 5'b00001, 3'd0, 4'b1000, 2, 0, "resume3");
    step(1'b0, 5'b10000, 3'd1, 4'b0100, 3, 0, "rot_again");
    step(1'b0, 5'b10000, 3'd1, 4'b0100, 3, 0, "rot_again2");
    step(1'b0, 5'b10010, 3'd4, 4'b0010, 3, 1, "barrier_rot");
    step(1'b0, 5'b10010, 3'd4, 4'b0010, 3, 1, "barrier_ignored");
    for (int k = 0; k < 2; k++) step(1'b0, 5'b10000, 3'd4, 4'b0010, 3, 1, "removing_rot");
    step(1'b0, 5'b10000, 3'd1, 4'b0100, 3, 1, "return_rot");
    step(1'b0, 5'b00100, 3'd3, 4'b0000, 3, 1, "under_rot");
    repeat (2) @(posedge clock);
    #1;
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got cyc=%0d required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/robo_seguidor.md
ROBO_SEGUIDOR -- requirements
Module: robo_seguidor

Interface
REQ-001 Parameter CNT_W, default 16: width of the passos and removidos counters.
REQ-002 Parameter ROT_LIMIT, default 8, legal range >= 1: maximum consecutive girar cycles before the block declares itself stuck.
REQ-003 Parameter REMOVE_CYCLES, default 4, legal range >= 1: number of cycles remover is held per removal.
REQ-004 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port head, input, 1: obstacle ahead.
REQ-007 Port left, input, 1: wall on left.
REQ-008 Port under, input, 1: floor hazard; forces stop.
REQ-009 Port barrier, input, 1: removable debris ahead.
REQ-010 Port retomar, input, 1: operator resume request from STANDBY.
REQ-011 Port avancar, output, 1: move forward.
REQ-012 Port girar, output, 1: rotate.
REQ-013 Port remover, output, 1: remove debris.
REQ-014 Port travado, output, 1: STANDBY was entered because the rotation limit expired.
REQ-015 Port estado, output, 3: current state encoding.
REQ-016 Port passos, output, CNT_W: count of avancar cycles.
REQ-017 Port removidos, output, CNT_W: count of removal episodes.

Function
REQ-018 The states SHALL be PROCURANDO=0, ROTACIONANDO=1, ACOMPANHANDO=2, STANDBY=3 and REMOVENDO=4; encodings 5-7 SHALL go to PROCURANDO on the next edge.
REQ-019 Outputs SHALL be Moore, decoded from the state register only: avancar in PROCURANDO/ACOMPANHANDO, girar in ROTACIONANDO, remover in REMOVENDO, none in STANDBY.
REQ-020 At most one of avancar, girar and remover SHALL be high in any cycle.
REQ-021 Transition priority in every state except STANDBY SHALL be: under=1 -> STANDBY; else barrier=1 (not already in REMOVENDO) -> REMOVENDO, saving the current state as return state; else the per-state rules below.
REQ-022 PROCURANDO: {head,left}=01 -> ACOMPANHANDO; head=1 -> ROTACIONANDO; 00 -> stay.
REQ-023 ROTACIONANDO: {head,left}=01 -> ACOMPANHANDO; otherwise stay and increment rot_cnt.
REQ-024 ROTACIONANDO: if no exit applies and rot_cnt==ROT_LIMIT-1 -> STANDBY with travado set, so girar is high exactly ROT_LIMIT consecutive cycles.
REQ-025 rot_cnt SHALL clear on any exit from ROTACIONANDO except to REMOVENDO; during REMOVENDO it SHALL be held.
REQ-026 ACOMPANHANDO: {head,left}=01 -> stay; 11 -> ROTACIONANDO; left=0 -> PROCURANDO.
REQ-027 REMOVENDO: remover SHALL stay high exactly REMOVE_CYCLES cycles, then return to the saved state; barrier is ignored there; under=1 aborts to STANDBY immediately.
REQ-028 removidos SHALL increment once per entry into REMOVENDO.
REQ-029 STANDBY: retomar=1 and under=0 -> PROCURANDO and clear travado; otherwise stay.
REQ-030 STANDBY: retomar=1 with under=1 SHALL be ignored.
REQ-031 passos SHALL increment on every cycle avancar is high.
REQ-032 passos and removidos SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-033 reset=1 on an edge SHALL force estado=PROCURANDO, clear rot_cnt, the removal counter, the saved state, passos, removidos and travado, with priority over all inputs, including mid-REMOVENDO or mid-ROTACIONANDO.
REQ-034 In the first cycle after reset the outputs SHALL be avancar=1, girar=0, remover=0, travado=0.

Structure
REQ-035 Package robo_pkg SHALL hold the state encodings, the 3-bit state width, and the sensor-vector bit indices.
REQ-036 A single sub-module contador_sat SHALL implement the saturating counter (parameter W; enable, clear), instantiated for passos and removidos.

Verification
REQ-037 Reset, then inputs 0000 for 5 cycles -> estado=0, avancar=1 each cycle, passos=5.
REQ-038 In PROCURANDO, drive left=1 -> ACOMPANHANDO next edge; then drive head=left=1 -> ROTACIONANDO; hold head=left=1 with ROT_LIMIT=8 -> girar high 8 cycles, then estado=3 and travado=1.
REQ-039 In ACOMPANHANDO, pulse barrier for 1 cycle, REMOVE_CYCLES=4 -> remover high 4 cycles, removidos=1, then estado=2.
REQ-040 In REMOVENDO (2nd cycle), set under=1 -> estado=3 next edge, remover=0.
REQ-041 In STANDBY with under=1 and retomar=1 -> stays 3; under=0 and retomar=1 -> estado=0, travado=0.
REQ-042 CNT_W=3, avancar for 10 cycles -> passos=7 and held; reset mid-ROTACIONANDO -> estado=0 and passos=0 next cycle.
